// File: rtl/turbo_pkg.sv
// Shared turbo decoder constants: word sizes, the
// info-block permutation and the exchange FSM encoding.
package turbo_pkg;

  localparam int LLR_BITS = 13;
  localparam int N_EXT    = 7;
  localparam int N_INFO   = 5;

  // out[i] = e[PI[i]] when interleaving; PI_INV undoes it
  localparam logic [2:0] PI [N_INFO] = '{
    3'd3, 3'd0, 3'd4, 3'd1, 3'd2
  };
  localparam logic [2:0] PI_INV [N_INFO] = '{
    3'd1, 3'd3, 3'd4, 3'd0, 3'd2
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_PERMUTE,
    ST_OUTPUT
  } state_t;

endpackage

// File: rtl/llr_sat_sub.sv
// One-stage pipelined e = L - A - S with saturation back
// to the LLR word range; shared across trellis steps.
module llr_sat_sub #(
  parameter int W = 13
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         i_valid,
  input  logic [W-1:0] i_l,
  input  logic [W-1:0] i_a,
  input  logic [3:0]   i_s,
  output logic         o_valid,
  output logic [W-1:0] o_e
);

  localparam logic signed [W+1:0] SMAX =
    {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SMIN =
    {3'b111, {(W-1){1'b0}}};

  logic signed [W+1:0] w_l;
  logic signed [W+1:0] w_a;
  logic signed [W+1:0] w_s;
  logic signed [W+1:0] w_diff;
  logic [W-1:0]        w_sat;

  assign w_l = {{2{i_l[W-1]}}, i_l};
  assign w_a = {{2{i_a[W-1]}}, i_a};
  assign w_s = {{(W-2){i_s[3]}}, i_s};
  assign w_diff = w_l - w_a - w_s;

  always_comb begin
    w_sat = w_diff[W-1:0];
    if (w_diff > SMAX) w_sat = SMAX[W-1:0];
    if (w_diff < SMIN) w_sat = SMIN[W-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      o_valid <= 1'b0;
      o_e     <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_e <= w_sat;
    end
  end

endmodule

// File: rtl/extrinsic_exchange.sv
// Extrinsic LLR exchange between SISO passes: subtract
// a-priori and systematic terms, permute, hand off.
module extrinsic_exchange #(
  parameter int LLR_BITS = turbo_pkg::LLR_BITS,
  parameter int N_EXT    = turbo_pkg::N_EXT,
  parameter int N_INFO   = turbo_pkg::N_INFO
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      siso_done_i,
  input  logic [N_EXT*LLR_BITS-1:0] llr_i,
  input  logic [N_EXT*LLR_BITS-1:0] apriori_i,
  input  logic [4*N_EXT-1:0]        sys_i,
  input  logic                      deint_i,
  input  logic                      ext_ready_i,
  output logic [N_EXT*LLR_BITS-1:0] ext_o,
  output logic                      ext_valid_o,
  output logic [N_INFO-1:0]         hard_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  import turbo_pkg::*;

  localparam int KW = $clog2(N_EXT);

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic [KW-1:0]       r_wk;
  logic [LLR_BITS-1:0] r_l [N_EXT];
  logic [LLR_BITS-1:0] r_a [N_EXT];
  logic [3:0]          r_s [N_EXT];
  logic [LLR_BITS-1:0] r_e [N_EXT];
  logic [N_EXT-1:0]    r_hk;
  logic                r_deint;
  logic [N_EXT*LLR_BITS-1:0] r_ext;
  logic [N_INFO-1:0]   r_hard;
  logic                r_valid;
  logic                r_busy;
  logic                r_overrun;

  logic                w_cap;
  logic                w_issue;
  logic                w_sub_v;
  logic [LLR_BITS-1:0] w_sub_e;
  logic [N_EXT*LLR_BITS-1:0] w_perm;
  logic [N_INFO-1:0]   w_hard;

  assign w_issue = (r_state == ST_COMPUTE);
  assign w_cap   = siso_done_i &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_OUTPUT) && ext_ready_i));

  llr_sat_sub #(
    .W (LLR_BITS)
  ) u_sub (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_valid   (w_issue),
    .i_l       (r_l[r_k]),
    .i_a       (r_a[r_k]),
    .i_s       (r_s[r_k]),
    .o_valid   (w_sub_v),
    .o_e       (w_sub_e)
  );

  // Tail elements never carry extrinsic info: left at zero
  always_comb begin
    w_perm = '0;
    w_hard = '0;
    for (int i = 0; i < N_INFO; i++) begin
      if (r_deint)
        w_perm[(N_EXT-1-i)*LLR_BITS +: LLR_BITS] =
          r_e[PI_INV[i]];
      else
        w_perm[(N_EXT-1-i)*LLR_BITS +: LLR_BITS] =
          r_e[PI[i]];
      w_hard[N_INFO-1-i] = r_hk[i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_deint <= 1'b0;
      for (int i = 0; i < N_EXT; i++) begin
        r_l[i] <= '0;
        r_a[i] <= '0;
        r_s[i] <= '0;
        r_e[i] <= '0;
      end
    end else begin
      if (w_cap) begin
        r_deint <= deint_i;
        for (int i = 0; i < N_EXT; i++) begin
          r_l[i] <= llr_i[(N_EXT-1-i)*LLR_BITS +: LLR_BITS];
          r_a[i] <= apriori_i[(N_EXT-1-i)*LLR_BITS +: LLR_BITS];
          r_s[i] <= sys_i[(N_EXT-1-i)*4 +: 4];
        end
      end
      if (w_sub_v) r_e[r_wk] <= w_sub_e;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_wk      <= '0;
      r_hk      <= '0;
      r_ext     <= '0;
      r_hard    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (siso_done_i && !w_cap && (r_state != ST_IDLE))
        r_overrun <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_cap) begin
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          r_wk      <= r_k;
          r_hk[r_k] <= ~r_l[r_k][LLR_BITS-1];
          if (r_k == KW'(N_EXT-1))
            r_state <= ST_PERMUTE;
          else
            r_k <= r_k + 1'b1;
        end
        ST_PERMUTE: begin
          // wait for the last pipelined result to land
          if (!w_sub_v) begin
            r_ext   <= w_perm;
            r_hard  <= w_hard;
            r_valid <= 1'b1;
            r_state <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (ext_ready_i) begin
            r_valid <= 1'b0;
            if (w_cap) begin
              r_k     <= '0;
              r_state <= ST_COMPUTE;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ext_o       = r_ext;
  assign hard_o      = r_hard;
  assign ext_valid_o = r_valid;
  assign busy_o      = r_busy;
  assign overrun_o   = r_overrun;

endmodule
